mem_stage_access: RTL and testbench
===================================

Name: mem_stage_access

Overview:
- MEM-stage consumer of the EXE/MEM pipeline register outputs (mem_*).
- Performs load/store accesses to a variable-latency data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding, issues a one-cycle branch redirect to fetch, and holds the MEM/WB pipeline register (wb_*).

Parameters:
- TIMEOUT, 255, max BUSY cycles without dm_ack before forced completion (1..255; counter is 8 bits).

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- mem_wreg  in  1  register-write enable of the instruction in MEM.
- mem_m2reg  in  1  load (result from memory).
- mem_wmem  in  1  store.
- mem_alu  in  32  ALU result / memory address.
- mem_b  in  32  store data (rt).
- mem_rn  in  5  destination register number.
- mem_branch  in  1  branch taken.
- mem_bpc  in  32  branch target.
- dm_req  out  1  memory request.
- dm_we  out  1  1 = write, 0 = read.
- dm_addr  out  32  memory address.
- dm_wdata  out  32  write data.
- dm_rdata  in  32  read data, valid when dm_ack = 1.
- dm_ack  in  1  access complete.
- mem_stall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM registers.
- pc_redirect  out  1  one-cycle redirect pulse to fetch.
- redirect_pc  out  32  redirect target.
- wb_wreg  out  1  WB register-write enable.
- wb_rn  out  5  WB destination.
- wb_data  out  32  WB data.
- dm_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset (clrn low, async): state IDLE; all outputs 0, including dm_timeout and the cycle counter. dm_req drops immediately, aborting any in-flight access; an ack arriving after reset is ignored.
- access = mem_m2reg | mem_wmem. mem_stall = (IDLE & access) | BUSY, combinational; it is 0 in DONE.
- FSM states:
  - IDLE:
    - No access: at the clock edge, wb_wreg <= mem_wreg, wb_rn <= mem_rn, wb_data <= mem_alu. If mem_branch = 1, pc_redirect <= 1 and redirect_pc <= mem_bpc; otherwise pc_redirect <= 0.
    - Access: latch dm_addr <= mem_alu, dm_wdata <= mem_b, dm_we <= mem_wmem, and the pending wreg/m2reg/rn. Clear the counter; wb_wreg <= 0 (bubble); go to BUSY.
  - BUSY:
    - dm_req = 1; addr/we/wdata held stable.
    - dm_ack = 1 at an edge: wb_wreg <= pending wreg, wb_rn <= pending rn, wb_data <= (pending m2reg ? dm_rdata : latched addr); go to DONE.
    - No ack: counter + 1 and wb_wreg <= 0.
    - counter == TIMEOUT - 1 with no ack: forced completion as if acked with rdata = 0; dm_timeout <= 1; go to DONE.
  - DONE:
    - dm_req = 0, wb_wreg <= 0 (bubble), then go to IDLE.
    - mem_* is not examined in DONE. EXE/MEM advances at this edge, so the same access is never reissued.
- dm_ack in IDLE or DONE is ignored.
- Latency:
  - Non-access instruction: 1 cycle.
  - Access: 2 + N cycles, where N = BUSY cycles until ack (minimum N = 1, i.e. 3 cycles).
- pc_redirect is high exactly one cycle per taken branch; a branch is never an access.
- dm_timeout clears only on reset.

Test Plan:
- ALU op (mem_wreg=1, mem_rn=5, mem_alu=0x1234, no access) -> next cycle wb_wreg=1, wb_rn=5, wb_data=0x1234; mem_stall never high.
- Load, mem_alu=0x40, dm_ack on the first BUSY cycle with dm_rdata=0xDEADBEEF -> dm_req high 1 cycle, dm_addr=0x40, dm_we=0; wb_data=0xDEADBEEF with wb_wreg=1 for exactly one cycle; mem_stall high 2 cycles.
- Store, mem_b=0xA5A5A5A5, ack after 4 BUSY cycles -> dm_we=1 and dm_wdata stable all 4 cycles; wb_wreg=0 throughout; no duplicate dm_req after DONE.
- Taken branch, mem_bpc=0x0000_0100 -> pc_redirect=1 and redirect_pc=0x100 for one cycle only.
- TIMEOUT=4, no ack -> dm_req drops after 4 BUSY cycles; dm_timeout=1 and stays 1; load retires with wb_data=0.
- clrn pulsed low mid-BUSY, ack asserted afterwards -> dm_req=0 immediately, all outputs 0, ack ignored, FSM stays IDLE.

Source files
------------

// File: rtl/mem_stage_access.sv
// MEM pipeline stage: variable-latency data-memory access over req/ack,
// upstream stall generation, one-cycle branch redirect and MEM/WB register.
module mem_stage_access #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic        mem_wmem,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_b,
  input  logic [4:0]  mem_rn,
  input  logic        mem_branch,
  input  logic [31:0] mem_bpc,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        wb_wreg,
  output logic [4:0]  wb_rn,
  output logic [31:0] wb_data,
  output logic        dm_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        pend_wreg;
  logic        pend_m2reg;
  logic [4:0]  pend_rn;
  logic        access;

  // Decode access and derive stall / request from the current state
  always_comb begin
    access    = mem_m2reg | mem_wmem;
    mem_stall = ((state == IDLE) && access) || (state == BUSY);
    dm_req    = (state == BUSY);
  end

  // Access sequencer with registered memory-side and writeback outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      cnt         <= '0;
      pend_wreg   <= 1'b0;
      pend_m2reg  <= 1'b0;
      pend_rn     <= '0;
      dm_we       <= 1'b0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      wb_wreg     <= 1'b0;
      wb_rn       <= '0;
      wb_data     <= '0;
      dm_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            dm_addr     <= mem_alu;
            dm_wdata    <= mem_b;
            dm_we       <= mem_wmem;
            pend_wreg   <= mem_wreg;
            pend_m2reg  <= mem_m2reg;
            pend_rn     <= mem_rn;
            cnt         <= '0;
            wb_wreg     <= 1'b0;
            pc_redirect <= 1'b0;
            state       <= BUSY;
          end else begin
            wb_wreg     <= mem_wreg;
            wb_rn       <= mem_rn;
            wb_data     <= mem_alu;
            pc_redirect <= mem_branch;
            if (mem_branch) begin
              redirect_pc <= mem_bpc;
            end
          end
        end
        BUSY: begin
          pc_redirect <= 1'b0;
          if (dm_ack) begin
            wb_wreg <= pend_wreg;
            wb_rn   <= pend_rn;
            wb_data <= pend_m2reg ? dm_rdata : dm_addr;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            // forced completion behaves like an ack carrying zero read data
            wb_wreg    <= pend_wreg;
            wb_rn      <= pend_rn;
            wb_data    <= pend_m2reg ? '0 : dm_addr;
            dm_timeout <= 1'b1;
            state      <= DONE;
          end else begin
            cnt     <= cnt + 8'd1;
            wb_wreg <= 1'b0;
          end
        end
        DONE: begin
          wb_wreg     <= 1'b0;
          pc_redirect <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_access.sv
// Self-checking bench for mem_stage_access: directed scenarios plus a
// randomized instruction stream checked against a transaction-level model.
module tb_mem_stage_access;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        clrn;
  logic        mem_wreg, mem_m2reg, mem_wmem, mem_branch;
  logic [31:0] mem_alu, mem_b, mem_bpc;
  logic [4:0]  mem_rn;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_stall, pc_redirect, wb_wreg, dm_timeout;
  logic [31:0] redirect_pc, wb_data;
  logic [4:0]  wb_rn;

  int checks = 0;
  int errors = 0;

  // model state
  logic        exp_to;
  logic [31:0] exp_rpc;

  mem_stage_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .clrn(clrn),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_wmem(mem_wmem),
    .mem_alu(mem_alu), .mem_b(mem_b), .mem_rn(mem_rn),
    .mem_branch(mem_branch), .mem_bpc(mem_bpc),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_data(wb_data), .dm_timeout(dm_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_nop();
    mem_wreg = 0; mem_m2reg = 0; mem_wmem = 0; mem_branch = 0;
    mem_alu = '0; mem_b = '0; mem_rn = '0; mem_bpc = '0;
  endtask

  task automatic test_reset();
    drive_nop();
    dm_ack = 0; dm_rdata = '0;
    clrn = 0;
    #12;
    checks++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, mem_stall, pc_redirect, redirect_pc,
         wb_wreg, wb_rn, wb_data, dm_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h stall=%b redir=%b rpc=%h wbw=%b rn=%0d wbd=%h to=%b, required all 0",
               dm_req, dm_we, dm_addr, dm_wdata, mem_stall, pc_redirect, redirect_pc,
               wb_wreg, wb_rn, wb_data, dm_timeout);
    end
    #1 clrn = 1;
    exp_to = 0; exp_rpc = '0;
    @(posedge clk); #1;
  endtask

  // Non-access instruction (ALU op or branch); expected result is one cycle later.
  task automatic run_simple(input logic wreg, input logic [4:0] rn, input logic [31:0] alu,
                            input logic br, input logic [31:0] bpc, input string nm);
    mem_wreg = wreg; mem_rn = rn; mem_alu = alu; mem_m2reg = 0; mem_wmem = 0;
    mem_branch = br; mem_bpc = bpc; mem_b = $urandom;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL %s_stall: got %b want 0", nm, mem_stall);
    end
    @(posedge clk); #1;
    if (br) exp_rpc = bpc;
    checks++;
    if (wb_wreg !== wreg || wb_rn !== rn || wb_data !== alu) begin
      errors++;
      $display("FAIL %s_wb: got wreg=%b rn=%0d data=%h want wreg=%b rn=%0d data=%h",
               nm, wb_wreg, wb_rn, wb_data, wreg, rn, alu);
    end
    checks++;
    if (pc_redirect !== br || redirect_pc !== exp_rpc) begin
      errors++;
      $display("FAIL %s_redirect: got %b/%h want %b/%h", nm, pc_redirect, redirect_pc, br, exp_rpc);
    end
    drive_nop();
    @(posedge clk); #1;
    checks++;
    if (pc_redirect !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: redirect=%b stall=%b want 0/0", nm, pc_redirect, mem_stall);
    end
  endtask

  // Load/store; memory acks on busy cycle ackn (>TO means never acked).
  task automatic run_access(input logic wreg, input logic m2reg, input logic wmem,
                            input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                            input int ackn, input logic [31:0] rdata, input string nm);
    int busy_exp;
    int req_cnt;
    int wbw_cnt;
    logic timed;
    logic [31:0] exp_data;
    timed    = (ackn > int'(TO));
    busy_exp = timed ? int'(TO) : ackn;
    exp_data = m2reg ? (timed ? 32'h0 : rdata) : alu;
    mem_wreg = wreg; mem_m2reg = m2reg; mem_wmem = wmem; mem_alu = alu;
    mem_b = b; mem_rn = rn; mem_branch = 0; mem_bpc = $urandom;
    dm_ack = 0;
    #1;
    checks++;
    if (mem_stall !== 1'b1 || dm_req !== 1'b0) begin
      errors++; $display("FAIL %s_issue: stall=%b req=%b want 1/0", nm, mem_stall, dm_req);
    end
    req_cnt = 0; wbw_cnt = 0;
    @(posedge clk); #1;
    // busy phase, bounded by the model's expected length plus slack
    for (int k = 1; k <= busy_exp + 2; k++) begin
      if (dm_req !== 1'b1) break;
      req_cnt++;
      if (wb_wreg) wbw_cnt++;
      if (dm_addr !== alu || dm_we !== wmem || dm_wdata !== b || mem_stall !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy%0d: addr=%h we=%b wd=%h stall=%b want %h/%b/%h/1",
                 nm, k, dm_addr, dm_we, dm_wdata, mem_stall, alu, wmem, b);
      end
      dm_ack   = (k == ackn);
      dm_rdata = (k == ackn) ? rdata : $urandom;
      @(posedge clk); #1;
    end
    dm_ack = 1'b0;
    checks++;
    if (req_cnt != busy_exp) begin
      errors++; $display("FAIL %s_req_cycles: got %0d want %0d", nm, req_cnt, busy_exp);
    end
    checks++;
    if (wbw_cnt != 0) begin
      errors++; $display("FAIL %s_busy_bubble: wb_wreg high %0d busy cycles want 0", nm, wbw_cnt);
    end
    exp_to = exp_to | timed;
    checks++;
    if (wb_wreg !== wreg || wb_rn !== rn || wb_data !== exp_data || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got wreg=%b rn=%0d data=%h stall=%b want %b/%0d/%h/0",
               nm, wb_wreg, wb_rn, wb_data, mem_stall, wreg, rn, exp_data);
    end
    checks++;
    if (dm_timeout !== exp_to) begin
      errors++; $display("FAIL %s_timeout_flag: got %b want %b", nm, dm_timeout, exp_to);
    end
    drive_nop();
    @(posedge clk); #1;
    checks++;
    if (wb_wreg !== 1'b0 || dm_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s_retire: wbw=%b req=%b stall=%b want 0/0/0", nm, wb_wreg, dm_req, mem_stall);
    end
  endtask

  task automatic test_alu();
    run_simple(1'b1, 5'd5, 32'h1234, 1'b0, 32'h0, "alu");
  endtask

  task automatic test_load();
    run_access(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 5'd9, 1, 32'hDEADBEEF, "load");
  endtask

  task automatic test_store();
    run_access(1'b0, 1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, 5'd0, 4, 32'h0, "store");
  endtask

  task automatic test_branch();
    run_simple(1'b0, 5'd0, 32'h0, 1'b1, 32'h0000_0100, "branch");
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 5'd3, 100, 32'h0, "timeout");
    run_simple(1'b1, 5'd7, 32'h77, 1'b0, 32'h0, "post_timeout");
    checks++;
    if (dm_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got %b want 1", dm_timeout);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_simple($urandom_range(0, 1) == 1, 5'($urandom), $urandom, 1'b0, 32'h0, "rnd_alu");
        1: run_simple(1'b0, 5'($urandom), $urandom, 1'b1, $urandom, "rnd_branch");
        2: run_access($urandom_range(0, 1) == 1, 1'b1, 1'b0, $urandom, $urandom, 5'($urandom),
                      $urandom_range(1, 6), $urandom, "rnd_load");
        default: run_access($urandom_range(0, 1) == 1, 1'b0, 1'b1, $urandom, $urandom, 5'($urandom),
                            $urandom_range(1, 6), $urandom, "rnd_store");
      endcase
    end
  endtask

  task automatic test_reset_mid_busy();
    mem_wreg = 1; mem_m2reg = 1; mem_wmem = 0; mem_alu = 32'h200; mem_rn = 5'd4;
    dm_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (dm_req !== 1'b1) begin
      errors++; $display("FAIL rst_busy_pre: req=%b want 1", dm_req);
    end
    clrn = 0;
    #1;
    checks++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, pc_redirect, redirect_pc,
         wb_wreg, wb_rn, wb_data, dm_timeout} !== '0) begin
      errors++;
      $display("FAIL rst_busy_outputs: req=%b addr=%h wbw=%b wbd=%h to=%b rpc=%h want all 0",
               dm_req, dm_addr, wb_wreg, wb_data, dm_timeout, redirect_pc);
    end
    drive_nop();
    #2 clrn = 1;
    exp_to = 0; exp_rpc = '0;
    dm_ack = 1; dm_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (dm_req !== 1'b0 || mem_stall !== 1'b0 || wb_wreg !== 1'b0 || wb_data !== 32'h0) begin
        errors++;
        $display("FAIL rst_late_ack%0d: req=%b stall=%b wbw=%b wbd=%h want 0/0/0/0",
                 k, dm_req, mem_stall, wb_wreg, wb_data);
      end
    end
    dm_ack = 0;
    run_simple(1'b1, 5'd1, 32'h55, 1'b0, 32'h0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_timeout();
    test_random();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
